// File: rtl/asic_iopoc_pkg.sv
// Shared constants for the IO-ring power-on-control sequencer:
// default parameters, FSM state encoding and a lowest-failing-segment helper.
package asic_iopoc_pkg;

  localparam int NSEG_DEF     = 4;
  localparam int DEBOUNCE_DEF = 8;
  localparam int STAGGER_DEF  = 16;
  localparam int TIMEOUT_DEF  = 256;

  // FSM states (legacy-compatible fixed encoding)
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_WAIT_GOOD = 3'd1;
  localparam state_t ST_STAGGER   = 3'd2;
  localparam state_t ST_READY     = 3'd3;
  localparam state_t ST_FAULT     = 3'd4;

  // Index of the lowest 0 bit; unused upper bits are padded with 1 by the caller.
  function automatic logic [3:0] lowest_zero(input logic [15:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (!v[i]) r = 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/asic_iopoc_debounce.sv
// One supply-good input: 2-flop synchronizer followed by a saturating
// debounce counter. dgood rises after DEBOUNCE consecutive synchronized 1s
// and drops on the edge after a synchronized 0.
module asic_iopoc_debounce
  import asic_iopoc_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic vin,
  output logic dgood
);

  localparam logic [7:0] CNT_MAX  = 8'(DEBOUNCE);
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE - 1);

  logic       s1;
  logic       s2;
  logic [7:0] cnt;

  // Synchronize vin, then count consecutive good samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      dgood <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop here sample the
      // pre-edge value, so s1 -> s2 -> cnt behaves as a true pipeline; the
      // second flop gives the first a full cycle to settle from metastability.
      s1 <= vin;
      s2 <= s1;
      if (!s2) begin
        cnt   <= '0;
        dgood <= 1'b0;
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + 8'd1;
        if (cnt >= CNT_LAST) dgood <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/asic_iopoc_seq.sv
// IO-ring power-on-control sequencer: waits for all debounced supply-good
// flags, enables ring segments one at a time STAGGER cycles apart, then
// releases poc. Any supply loss while enabling or running trips a sticky
// fault that only start=0 clears.
module asic_iopoc_seq
  import asic_iopoc_pkg::*;
#(
  parameter int NSEG     = NSEG_DEF,
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int STAGGER  = STAGGER_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic [NSEG-1:0]                         vgood,
  output logic [NSEG-1:0]                         seg_en,
  output logic                                    poc,
  output logic                                    ready,
  output logic                                    fault,
  output logic [((NSEG > 1) ? $clog2(NSEG) : 1)-1:0] fault_seg
);

  localparam int FSW = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int IW  = $clog2(NSEG + 1);

  localparam logic [15:0]   TMO_LIMIT = 16'(TIMEOUT);
  localparam logic [15:0]   STG_LAST  = 16'(STAGGER - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NSEG);
  localparam logic [NSEG-1:0] SEG_ONE = NSEG'(1);

  state_t        state;
  logic [15:0]   tmr;
  logic [IW-1:0] idx;
  logic [NSEG-1:0] dgood;
  logic [15:0]   dg_pad;
  logic [3:0]    low_bad;

  // One synchronizer/debouncer per ring segment.
  for (genvar g = 0; g < NSEG; g++) begin : g_db
    asic_iopoc_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
      .clk   (clk),
      .reset (reset),
      .vin   (vgood[g]),
      .dgood (dgood[g])
    );
  end

  // Pad dgood to 16 bits with "good" so the search only finds real segments.
  always_comb begin
    // NOTE: assign a full default before the partial overwrite so no bit
    // of dg_pad is left unassigned on any path (which would infer a latch).
    dg_pad            = '1;
    dg_pad[NSEG-1:0]  = dgood;
    low_bad           = lowest_zero(dg_pad);
  end

  // Sequencer FSM; every output is a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      seg_en    <= '0;
      poc       <= 1'b1;
      ready     <= 1'b0;
      fault     <= 1'b0;
      fault_seg <= '0;
      tmr       <= '0;
      idx       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          seg_en <= '0;
          poc    <= 1'b1;
          ready  <= 1'b0;
          if (start) begin
            state <= ST_WAIT_GOOD;
            tmr   <= '0;
          end
        end

        ST_WAIT_GOOD: begin
          if (!start) begin
            state <= ST_IDLE;
          end else if (&dgood) begin
            state  <= ST_STAGGER;
            seg_en <= SEG_ONE;
            idx    <= IW'(1);
            tmr    <= '0;
          end else if (tmr == TMO_LIMIT) begin
            state     <= ST_FAULT;
            fault     <= 1'b1;
            fault_seg <= '0;
          end else begin
            tmr <= tmr + 16'd1;
          end
        end

        ST_STAGGER, ST_READY: begin
          if (!start) begin
            // Shutdown request wins over a same-cycle supply loss.
            state  <= ST_IDLE;
            seg_en <= '0;
            poc    <= 1'b1;
            ready  <= 1'b0;
          end else if (!(&dgood)) begin
            state     <= ST_FAULT;
            seg_en    <= '0;
            poc       <= 1'b1;
            ready     <= 1'b0;
            fault     <= 1'b1;
            fault_seg <= low_bad[FSW-1:0];
          end else if (state == ST_STAGGER) begin
            if (tmr == STG_LAST) begin
              tmr <= '0;
              if (idx == IDX_LAST) begin
                state <= ST_READY;
                poc   <= 1'b0;
                ready <= 1'b1;
              end else begin
                seg_en <= seg_en | (SEG_ONE << idx);
                idx    <= idx + IW'(1);
              end
            end else begin
              tmr <= tmr + 16'd1;
            end
          end
        end

        ST_FAULT: begin
          seg_en <= '0;
          poc    <= 1'b1;
          ready  <= 1'b0;
          if (!start) begin
            state     <= ST_IDLE;
            fault     <= 1'b0;
            fault_seg <= '0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/asic_iopoc_seq.md
ASIC_IOPOC_SEQ -- requirements
Module: asic_iopoc_seq

Interface
REQ-001 Parameter NSEG, default 4: number of IO-ring supply segments sequenced (legal range 1..16).
REQ-002 Parameter DEBOUNCE, default 8: consecutive synchronized-good cycles before a segment counts as good (legal range 1..255).
REQ-003 Parameter STAGGER, default 16: cycles between successive segment enables (legal range 1..65535).
REQ-004 Parameter TIMEOUT, default 256: cycle limit in WAIT_GOOD before a fault (legal range 1..65535).
REQ-005 Port clk, input, 1: the single block clock.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port start, input, 1: level request to power up the ring; deassertion requests shutdown.
REQ-008 Port vgood, input, NSEG: per-segment supply-good flags, asynchronous to clk.
REQ-009 Port seg_en, output, NSEG: per-segment ring enable.
REQ-010 Port poc, output, 1: power-on-control; 1 holds all pads in the safe state.
REQ-011 Port ready, output, 1: ring fully enabled and poc released.
REQ-012 Port fault, output, 1: sticky fault indication.
REQ-013 Port fault_seg, output, max(1,$clog2(NSEG)): lowest-index segment that caused the fault; 0 on timeout.

Function
REQ-014 Each vgood bit SHALL pass through a 2-flop synchronizer, then a saturating debounce counter; dgood[i]=1 after DEBOUNCE consecutive synchronized-1 samples; a synchronized 0 SHALL clear the counter and dgood[i] on the next edge.
REQ-015 FSM states SHALL be IDLE, WAIT_GOOD, STAGGER, READY, FAULT; all outputs SHALL be registered.
REQ-016 IDLE: poc=1, seg_en=0, ready=0; start=1 -> WAIT_GOOD next edge, timeout counter cleared.
REQ-017 WAIT_GOOD: when all dgood=1 at edge T -> STAGGER, seg_en[0]=1 at T+1; if timer reaches TIMEOUT first -> FAULT, fault_seg=0.
REQ-018 STAGGER: seg_en[k] SHALL rise at T+1+k*STAGGER; enabled bits stay set; poc=0 and ready=1 at T+1+NSEG*STAGGER, state READY.
REQ-019 In STAGGER or READY, dgood[i]=0 for any i -> FAULT next edge: seg_en=0, poc=1, ready=0, fault=1, fault_seg=lowest failing i.
REQ-020 Simultaneous multi-segment failure SHALL report the lowest index.
REQ-021 start=0 in WAIT_GOOD, STAGGER or READY -> IDLE next edge, seg_en=0, poc=1, ready=0, no fault; start=0 takes priority over a same-cycle dgood loss.
REQ-022 FAULT: seg_en=0, poc=1; exit to IDLE only when start=0, which also clears fault and fault_seg.
REQ-023 The stagger timer SHALL be 16 bits and the segment index $clog2(NSEG+1) bits; neither SHALL wrap within one sequence.
REQ-024 NSEG=1 SHALL produce seg_en[0] at T+1 and ready at T+1+STAGGER.

Reset
REQ-025 reset=1 SHALL asynchronously force state IDLE, seg_en=0, poc=1, ready=0, fault=0, fault_seg=0, and all synchronizers, debounce counters and timers to 0.
REQ-026 Reset deassertion SHALL be followed by normal operation from the first subsequent edge, with no release synchronization inside the block.

Structure
REQ-027 The FSM state enum and default parameter constants SHALL live in shared package asic_iopoc_pkg.
REQ-028 Per-segment synchronization and debounce SHALL be sub-module asic_iopoc_debounce, instantiated NSEG times.

Verification (NSEG=4, DEBOUNCE=8, STAGGER=16, TIMEOUT=256)
REQ-029 Reset, start=1, vgood=4'hF at cycle 0 -> dgood all 1 by cycle 10; seg_en 1,3,7,F at T+1, +17, +33, +49; poc=0 and ready=1 at T+65.
REQ-030 vgood[2] glitches low 1 cycle during debounce -> counter restarts; seg_en[0] delayed by 9 cycles.
REQ-031 In READY, vgood=4'b0101 -> fault=1, fault_seg=1, seg_en=0, poc=1 within 4 cycles; start=0 -> IDLE with fault=0.
REQ-032 start=1, vgood=4'h7 held -> FAULT at cycle 257 after WAIT_GOOD entry, fault_seg=0.
REQ-033 start drops at T+20 (seg_en=3) -> next edge seg_en=0, poc=1, no fault.
REQ-034 reset pulsed mid-STAGGER, asynchronous to clk -> outputs reach reset values before the next clk edge.
